// File: rtl/quick_spi_slave.sv
// QuickSPI responder: oversamples sclk/ss_n/mosi in the clk domain, assembles an
// LSB-first receive word and shifts a preloaded reply word out on miso.
module quick_spi_slave #(
  parameter int INCOMING_DATA_WIDTH = 16,
  parameter int OUTGOING_DATA_WIDTH = 8,
  parameter bit CPOL                = 1'b0,
  parameter bit CPHA                = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sclk,
  input  logic                           ss_n,
  input  logic                           mosi,
  output logic                           miso,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  input  logic                           load,
  output logic                           ready,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           end_of_transaction,
  output logic [7:0]                     bit_count,
  output logic                           busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic mosi_p0, mosi_p1;

  logic [OUTGOING_DATA_WIDTH-1:0] tx_buf;
  logic [INCOMING_DATA_WIDTH-1:0] rx_shift;
  logic [INCOMING_DATA_WIDTH-1:0] rx_next;
  logic [7:0]                     bit_cnt;
  logic [7:0]                     tx_idx;
  logic                           miso_q;
  logic                           miso_en;
  logic                           eot_q;
  logic                           tx_bit;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall, ss_rise;

  // Synchronizer stages p0/p1, history p2; mosi needs no history since only its level is used
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_p0 <= CPOL;
      sclk_p1 <= CPOL;
      sclk_p2 <= CPOL;
      ss_p0   <= 1'b1;
      ss_p1   <= 1'b1;
      ss_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_p0   <= ss_n;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise   = sclk_p1 & ~sclk_p2;
  assign sclk_fall   = ~sclk_p1 & sclk_p2;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_p1 & ss_p2;
  assign ss_rise     = ss_p1 & ~ss_p2;

  // Counter values past the word widths match no bit, so late RX bits drop and TX pads with 0
  always_comb begin
    rx_next = rx_shift;
    for (int i = 0; i < INCOMING_DATA_WIDTH; i++) begin
      if (int'(bit_cnt) == i) rx_next[i] = mosi_p1;
    end
  end

  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < OUTGOING_DATA_WIDTH; i++) begin
      if (int'(tx_idx) == i) tx_bit = tx_buf[i];
    end
  end

  // Transaction control stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tx_buf        <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      tx_idx        <= '0;
      miso_q        <= 1'b0;
      miso_en       <= 1'b0;
      eot_q         <= 1'b0;
      incoming_data <= '0;
      bit_count     <= '0;
    end else begin
      eot_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load) tx_buf <= outgoing_data;
          if (ss_fall) begin
            state    <= ACTIVE;
            rx_shift <= '0;
            bit_cnt  <= '0;
            miso_en  <= 1'b1;
            if (CPHA) begin
              miso_q <= 1'b0;
              tx_idx <= 8'd0;
            end else begin
              miso_q <= load ? outgoing_data[0] : tx_buf[0];
              tx_idx <= 8'd1;
            end
          end
        end
        ACTIVE: begin
          // Deselect wins over any sclk edge seen in the same cycle
          if (ss_rise) begin
            state         <= DONE;
            incoming_data <= rx_shift;
            bit_count     <= bit_cnt;
            eot_q         <= 1'b1;
            miso_en       <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 8'd1;
            end
            if (shift_edge) begin
              miso_q <= tx_bit;
              if (tx_idx != 8'hFF) tx_idx <= tx_idx + 8'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign miso               = miso_en ? miso_q : 1'bz;
  assign ready              = (state == IDLE);
  assign busy               = (state == ACTIVE);
  assign end_of_transaction = eot_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Scoreboarded bench for quick_spi_slave: one instance in mode 0 (CPOL=0,CPHA=0)
// and one in mode 3 (CPOL=1,CPHA=1), driven by a bit-level SPI master.
module tb_quick_spi_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       sclk0, ss0, mosi0, load0, ready0, eot0, busy0;
  logic [7:0] out0, bc0;
  logic [15:0] in0;
  wire        miso0;

  logic       sclk3, ss3, mosi3, load3, ready3, eot3, busy3;
  logic [7:0] out3, bc3;
  logic [15:0] in3;
  wire        miso3;

  // Undriven miso reads 1 on the mode-0 link and 0 on the mode-3 link
  pullup   pu0 (miso0);
  pulldown pd3 (miso3);

  quick_spi_slave #(.INCOMING_DATA_WIDTH(16), .OUTGOING_DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .ss_n(ss0), .mosi(mosi0), .miso(miso0),
    .outgoing_data(out0), .load(load0), .ready(ready0), .incoming_data(in0),
    .end_of_transaction(eot0), .bit_count(bc0), .busy(busy0));

  quick_spi_slave #(.INCOMING_DATA_WIDTH(16), .OUTGOING_DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .reset(reset), .sclk(sclk3), .ss_n(ss3), .mosi(mosi3), .miso(miso3),
    .outgoing_data(out3), .load(load3), .ready(ready3), .incoming_data(in3),
    .end_of_transaction(eot3), .bit_count(bc3), .busy(busy3));

  typedef struct {
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_m0, tx_m3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t expect_of(input logic [319:0] d, input int n);
    exp_t e;
    for (int b = 0; b < 16; b++) e.data[b] = (b < n) ? d[b] : 1'b0;
    e.cnt = (n > 255) ? 8'd255 : 8'(n);
    return e;
  endfunction

  function automatic logic tx_expect(input logic [7:0] tx, input int i);
    return (i < 8) ? tx[i] : 1'b0;
  endfunction

  // Monitors: every end_of_transaction strobe must match the oldest expected transfer
  always @(negedge clk) begin
    if (eot0 === 1'b1) begin
      if (q0.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL eot0_unexpected: got strobe, expected none (data %0h count %0d)", in0, bc0);
      end else begin
        e0 = q0.pop_front();
        chk("eot0_data", 32'(in0), 32'(e0.data));
        chk("eot0_count", 32'(bc0), 32'(e0.cnt));
        chk("eot0_busy", 32'(busy0), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (eot3 === 1'b1) begin
      if (q3.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL eot3_unexpected: got strobe, expected none (data %0h count %0d)", in3, bc3);
      end else begin
        e3 = q3.pop_front();
        chk("eot3_data", 32'(in3), 32'(e3.data));
        chk("eot3_count", 32'(bc3), 32'(e3.cnt));
        chk("eot3_busy", 32'(busy3), 32'd0);
      end
    end
  end

  task automatic load_m0(input logic [7:0] v);
    out0 = v; load0 = 1'b1; cycles(1); load0 = 1'b0;
    tx_m0 = v;
  endtask

  task automatic load_m3(input logic [7:0] v);
    out3 = v; load3 = 1'b1; cycles(1); load3 = 1'b0;
    tx_m3 = v;
  endtask

  // Mode 0 master: sample miso just before each rising sclk, change mosi on the falling one
  task automatic xfer0(input logic [319:0] d, input int n, input bit busy_load, input bit no_end);
    ss0 = 1'b0;
    cycles(6);
    chk("busy0_active", 32'(busy0), 32'd1);
    for (int i = 0; i < n; i++) begin
      mosi0 = d[i];
      cycles(4);
      chk("miso0_bit", 32'(miso0), 32'(tx_expect(tx_m0, i)));
      sclk0 = 1'b1;
      cycles(4);
      sclk0 = 1'b0;
      if (busy_load && i == 2) begin
        out0 = 8'hFF; load0 = 1'b1; cycles(1); load0 = 1'b0;
      end
    end
    cycles(4);
    if (!no_end) begin
      q0.push_back(expect_of(d, n));
      ss0 = 1'b1;
      cycles(2);
      chk("busy0_hold", 32'(busy0), 32'd1);
      cycles(1);
      chk("busy0_fall", 32'(busy0), 32'd0);
      chk("eot0_high", 32'(eot0), 32'd1);
      chk("ready0_during_eot", 32'(ready0), 32'd0);
      cycles(1);
      chk("eot0_single", 32'(eot0), 32'd0);
      chk("ready0_back", 32'(ready0), 32'd1);
      chk("miso0_released", 32'(miso0), 32'd1);
      cycles(3);
    end
  endtask

  // Mode 3 master: falling sclk is the shift edge, rising sclk is the sampling edge
  task automatic xfer3(input logic [319:0] d, input int n);
    ss3 = 1'b0;
    cycles(6);
    chk("busy3_active", 32'(busy3), 32'd1);
    for (int i = 0; i < n; i++) begin
      sclk3 = 1'b0;
      mosi3 = d[i];
      if (i == 0) begin
        cycles(2);
        chk("miso3_before_3rd_edge", 32'(miso3), 32'd0);
        cycles(1);
        chk("miso3_at_3rd_edge", 32'(miso3), 32'(tx_m3[0]));
        cycles(1);
      end else begin
        cycles(4);
      end
      chk("miso3_bit", 32'(miso3), 32'(tx_expect(tx_m3, i)));
      sclk3 = 1'b1;
      cycles(4);
    end
    q3.push_back(expect_of(d, n));
    ss3 = 1'b1;
    cycles(3);
    chk("busy3_fall", 32'(busy3), 32'd0);
    cycles(1);
    chk("ready3_back", 32'(ready3), 32'd1);
    chk("miso3_released", 32'(miso3), 32'd0);
    cycles(3);
  endtask

  function automatic logic [319:0] rand_bits();
    logic [319:0] d;
    for (int k = 0; k < 10; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end of the stimulus");
    $fatal(1);
  end

  initial begin
    logic [319:0] d;
    int n;
    reset = 1'b1;
    sclk0 = 1'b0; ss0 = 1'b1; mosi0 = 1'b0; load0 = 1'b0; out0 = 8'h00;
    sclk3 = 1'b1; ss3 = 1'b1; mosi3 = 1'b0; load3 = 1'b0; out3 = 8'h00;
    tx_m0 = 8'h00; tx_m3 = 8'h00;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_eot0", 32'(eot0), 32'd0);
    chk("rst_data0", 32'(in0), 32'd0);
    chk("rst_count0", 32'(bc0), 32'd0);
    chk("rst_miso0", 32'(miso0), 32'd1);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_miso3", 32'(miso3), 32'd0);

    // Nominal 16-bit word with a 0x3C reply
    load_m0(8'h3C);
    d = '0; d[15:0] = 16'hA55A;
    xfer0(d, 16, 1'b0, 1'b0);

    // Short transfer 1,0,1,1,0; reply buffer replays 0x3C
    d = '0; d[4:0] = 5'b01101;
    xfer0(d, 5, 1'b0, 1'b0);

    // Overlong transfer saturates the count
    xfer0(rand_bits(), 300, 1'b0, 1'b0);

    // Load during ACTIVE is ignored, and the old word is replayed afterwards
    load_m0(8'h81);
    xfer0(rand_bits(), 16, 1'b1, 1'b0);
    xfer0(rand_bits(), 16, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      load_m0(8'($urandom()));
      n = int'($urandom_range(1, 24));
      xfer0(rand_bits(), n, 1'b0, 1'b0);
    end

    // Mode 3: mirrored nominal word, then random traffic
    load_m3(8'($urandom()) | 8'h01);
    d = '0; d[15:0] = 16'hA55A;
    xfer3(d, 16);
    for (int t = 0; t < 2; t++) begin
      load_m3(8'($urandom()) | 8'h01);
      n = int'($urandom_range(1, 20));
      xfer3(rand_bits(), n);
    end

    // Reset after 7 bits aborts silently
    load_m0(8'h5A);
    xfer0(rand_bits(), 7, 1'b0, 1'b1);
    reset = 1'b1;
    cycles(2);
    chk("abort_miso0", 32'(miso0), 32'd1);
    chk("abort_eot0", 32'(eot0), 32'd0);
    ss0 = 1'b1;
    cycles(3);
    reset = 1'b0;
    tx_m0 = 8'h00;
    tx_m3 = 8'h00;
    cycles(4);
    chk("abort_ready0", 32'(ready0), 32'd1);
    chk("abort_busy0", 32'(busy0), 32'd0);
    d = '0; d[15:0] = 16'h1234;
    xfer0(d, 16, 1'b0, 1'b0);

    cycles(4);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quick_spi_slave.md
# quick_spi_slave

SPI responder for the QuickSPI family: it answers a QuickSPI master on a second FPGA, or a loopback master in test, using the same LSB-first framing. The SPI pins are sampled in the local `clk` domain and no SPI clock is used as a clock. Data arriving on `mosi` is assembled into a word and published with a one-cycle valid strobe when `ss_n` deasserts. A preloaded reply word is shifted out on `miso`. It sits between the chip-select pins and a register/command decoder.

## Interface
Parameters:
- `INCOMING_DATA_WIDTH`, default 16: width of the word received on `mosi`.
- `OUTGOING_DATA_WIDTH`, default 8: width of the reply word driven on `miso`.
- `CPOL`, default 0: `sclk` idle level.
- `CPHA`, default 0:
  - 0: sample on the leading edge, shift on the trailing edge.
  - 1: shift on the leading edge, sample on the trailing edge.

Ports:
- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master; asynchronous.
- `ss_n`  in  1  slave select, active low; asynchronous.
- `mosi`  in  1  master data; asynchronous.
- `miso`  out  1  reply data; 1'bz when not selected.
- `outgoing_data`  in  OUTGOING_DATA_WIDTH  reply word to load.
- `load`  in  1  loads `outgoing_data` into the TX buffer; honoured only while `ready`=1.
- `ready`  out  1  high in IDLE.
- `incoming_data`  out  INCOMING_DATA_WIDTH  last received word.
- `end_of_transaction`  out  1  one-cycle strobe; `incoming_data` and `bit_count` are valid on it.
- `bit_count`  out  8  number of sampling edges seen in the last transaction; saturates at 255.
- `busy`  out  1  high while selected.

## Operation
- **Synchronizers:** `sclk`, `ss_n` and `mosi` each pass through a 2-FF synchronizer followed by a third history FF.
  - An edge is detected when stage 2 differs from stage 3.
  - Synchronized `mosi` is taken from stage 2.
- **State machine:** IDLE -> ACTIVE -> DONE -> IDLE.
  - **IDLE:**
    - `ready`=1 and `miso`=z.
    - `load`=1 copies `outgoing_data` into the TX buffer.
    - A detected `ss_n` fall moves to ACTIVE and clears the RX shift register and the bit counter.
    - If `load` and the `ss_n` fall are detected in the same cycle, the newly loaded data is used.
  - **ACTIVE:**
    - `busy`=1 and `load` is ignored.
    - Leading and trailing edges are decoded from `CPOL`.
    - Sampling edge:
      - sample bit k (k = counter) into RX bit k when k < INCOMING_DATA_WIDTH;
      - bits beyond the width are dropped;
      - increment the counter, saturating at 255.
    - Shift edge: drive TX bit m on `miso`. When m >= OUTGOING_DATA_WIDTH, drive 0.
    - `CPHA`=0: TX bit 0 is driven on ACTIVE entry. Each trailing edge advances m.
    - `CPHA`=1: `miso` is driven 0 on entry. Leading edge n (n = 0, 1, …) drives TX bit n.
    - A detected `ss_n` rise moves to DONE. It takes priority over any `sclk` edge detected in the same cycle, and that edge is ignored.
  - **DONE** (one cycle):
    - Register the RX shift register into `incoming_data` and the counter into `bit_count`.
    - Pulse `end_of_transaction`=1, set `miso`=z, return to IDLE.
    - Unreceived RX bits read 0.
- **TX buffer:** retained across transactions; a transaction without a preceding `load` replays the previous word.
- **Reset:**
  - Output values:
    - `miso`=z
    - `incoming_data`=0
    - `bit_count`=0
    - `end_of_transaction`=0
    - `busy`=0
    - `ready`=1 on the first cycle after reset.
  - Internal state:
    - TX buffer = 0
    - all synchronizer stages = idle levels (`sclk`=CPOL, `ss_n`=1, `mosi`=0)
    - state = IDLE
  - Reset while selected aborts the transaction with no `end_of_transaction`.
  - If `ss_n` is still low after reset, it is treated as a fall, because the history FF resets to 1. The master must therefore deassert select before reusing the link.

## Timing
- Pin-to-action latency is 3 `clk` rising edges. The pin is captured on edge 1, reaches stage 2 on edge 2, and the registered action takes effect on edge 3.
- The first `miso` bit (`CPHA`=0) is valid 3 edges after `ss_n` falls. The master must wait at least 4 `clk` periods before the first leading `sclk` edge.
- `sclk` high and low phases must each be at least 3 `clk` periods. `miso` changes 3 edges after the shift edge.
- `mosi` must be stable from 1 `clk` before to 2 `clk` after each sampling edge at the pin.
- Deassertion sequence:
  - `busy` falls 3 edges after `ss_n` rises, on entry to DONE.
  - `end_of_transaction` is high for exactly the following cycle.
  - `ready` rises one cycle after that.
- `load` is accepted in the same cycle it is presented while `ready`=1.

## Test plan
- **CPOL=0, CPHA=0, 16-bit receive:** master sends 0xA55A LSB-first over 16 clocks at `clk`/8, `outgoing_data`=0x3C loaded.
  - `incoming_data`=0xA55A and `bit_count`=16 with a single-cycle `end_of_transaction`.
  - `miso` carries 0,0,1,1,1,1,0,0, then 0 for bits 8-15.
- **Short transfer:** 5 bits 1,0,1,1,0 -> `incoming_data`=0x000D, `bit_count`=5.
- **Overlong transfer:** 300 `sclk` cycles -> `bit_count`=255 and `incoming_data` holds the first 16 bits.
- **Load while busy:** `load` with 0xFF during ACTIVE, prior load 0x81.
  - The current transaction sends 0x81.
  - The next transaction without a new `load` still sends 0x81.
- **CPOL=1, CPHA=1:**
  - Mirrored stimulus -> same received word as the first scenario.
  - `miso` bit 0 appears 3 edges after the first falling `sclk` edge.
- **Reset mid-transaction:** `reset` pulse after 7 bits.
  - No `end_of_transaction` and `miso`=z.
  - Master deasserts `ss_n`, then runs a fresh 16-bit transfer of 0x1234 -> `incoming_data`=0x1234.
